// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Framing errors park the receiver in BREAK until the line returns high.
module uart_rx #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int OS_COUNT = CLK_FREQ / (BAUD_RATE * 16);
    localparam int OS_W     = (OS_COUNT > 1) ? $clog2(OS_COUNT) : 1;
    localparam logic [OS_W-1:0] OS_MAX = OS_W'(OS_COUNT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic            rx_m;
    logic            rx_s;
    logic [OS_W-1:0] os_cnt;
    logic            os_tick;
    logic [2:0]      state;
    logic [3:0]      tcnt;
    logic [2:0]      bidx;
    logic [7:0]      shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Registered tick keeps the first tick OS_COUNT clocks after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt  <= '0;
            os_tick <= 1'b0;
        end else if (os_cnt == OS_MAX) begin
            os_cnt  <= '0;
            os_tick <= 1'b1;
        end else begin
            os_cnt  <= os_cnt + 1'b1;
            os_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tcnt      <= 4'd0;
            bidx      <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (os_tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state <= S_START;
                            tcnt  <= 4'd0;
                        end
                    end
                    S_START: begin
                        if (tcnt == 4'd7) begin
                            tcnt <= 4'd0;
                            bidx <= 3'd0;
                            state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (tcnt == 4'd15) begin
                            shreg[bidx] <= rx_s;
                            tcnt        <= 4'd0;
                            if (bidx == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                bidx <= bidx + 3'd1;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (tcnt == 4'd15) begin
                            data <= shreg;
                            tcnt <= 4'd0;
                            bidx <= 3'd0;
                            if (rx_s) begin
                                valid <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tcnt  <= 4'd0;
                        bidx  <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a frame-level queue of expected
// pulses and the last loaded byte act as the reference model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] d;
        logic       err;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_data = 8'h00;
    int         gl_off[5] = '{2, 3, 4, 12, 13};

    uart_rx #(
        .CLK_FREQ (16_000_000),
        .BAUD_RATE(1_000_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit period of 16 clocks, optionally with a 1-clock glitch.
    task automatic send_bit(input logic v, input int g);
        for (int i = 0; i < 16; i++) begin
            rx = (i == g) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic glitch);
        exp_t e;
        e.d   = b;
        e.err = ~stop;
        q.push_back(e);
        send_bit(1'b0, -1);
        for (int k = 0; k < 8; k++)
            send_bit(b[k], glitch ? gl_off[$urandom_range(0, 4)] : -1);
        send_bit(stop, -1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ref_data = 8'h00;
            q.delete();
        end
        if (valid || frame_err) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {valid, frame_err}, 2'b00);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {valid, frame_err},
                      e.err ? 2'b01 : 2'b10);
                check("pulse_data", data, e.d);
                ref_data = e.d;
            end
        end
        check("data_hold", data, ref_data);
    end

    initial begin
        logic [7:0] b;
        logic       st;
        logic       gl;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(8);
        check("a5_data", data, 8'hA5);
        check("a5_busy", busy, 1'b0);

        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(2);
        check("glitch_start_busy", busy, 1'b1);
        idle(12);
        check("glitch_idle_busy", busy, 1'b0);
        check("glitch_data", data, 8'hA5);

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(40);
        check("brk_busy", busy, 1'b1);
        check("brk_data", data, 8'h3C);
        rx = 1'b1;
        idle(6);
        check("brk_exit_busy", busy, 1'b0);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(10);
        check("b2b_data", data, 8'hFF);

        b = 8'h55;
        send_bit(1'b0, -1);
        for (int k = 0; k < 4; k++) send_bit(b[k], -1);
        rx = b[4];
        idle(8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", valid, 1'b0);
        idle(3);
        rst_n = 1'b1;
        rx    = 1'b1;
        idle(20);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_data", data, 8'h00);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(8);
        check("r81_data", data, 8'h81);

        send_frame(8'h96, 1'b1, 1'b1);
        idle(8);
        check("g96_data", data, 8'h96);

        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            gl = 1'($urandom_range(0, 1));
            send_frame(b, st, gl);
            if (!st) begin
                rx = 1'b1;
                idle(4 + $urandom_range(0, 10));
            end else begin
                idle($urandom_range(0, 10));
            end
        end

        rx = 1'b1;
        for (int i = 0; i < 400 && (q.size() != 0 || busy); i++) idle(1);
        check("drain_pending", q.size(), 0);
        check("end_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have localparam OS_COUNT = CLK_FREQ / (BAUD_RATE*16), integer-truncated, clocks per 16x oversample tick; OS_COUNT >= 1.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  8  last received byte, LSB received first.
REQ-008 SHALL have port valid  output  1  one-clock pulse: data holds a correctly framed byte.
REQ-009 SHALL have port frame_err  output  1  one-clock pulse: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (rx_s).
REQ-012 SHALL generate os_tick with a free-running counter 0..OS_COUNT-1, pulsing high one clock when it wraps.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK with a 4-bit tick counter (tcnt) and 3-bit bit index (bidx).
REQ-014 SHALL, in IDLE, on os_tick with rx_s=0, enter START with tcnt=0.
REQ-015 SHALL, in START, increment tcnt per os_tick; on the os_tick where tcnt=7: rx_s=0 -> DATA with tcnt=0, bidx=0; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-016 SHALL, in DATA, on the os_tick where tcnt=15, shift rx_s into shift-register bit bidx (LSB first) and reset tcnt; after bidx=7 enter STOP, else increment bidx.
REQ-017 SHALL, in STOP, on the os_tick where tcnt=15, sample rx_s: 1 -> load data, pulse valid, go IDLE; 0 -> load data, pulse frame_err, go BREAK.
REQ-018 SHALL, in BREAK, remain until rx_s=1 on an os_tick, then go IDLE; no start detection while in BREAK.
REQ-019 SHALL assert valid/frame_err exactly one clock, in the clock after the stop-sample os_tick; never both in one clock.
REQ-020 SHALL hold data stable between loads; data changes only in the clock valid or frame_err is pulsed.
REQ-021 SHALL ignore rx changes between sample points; only mid-bit samples (START tcnt=7, DATA/STOP tcnt=15) affect state.
REQ-022 SHALL accept a new start bit in IDLE on the os_tick immediately after returning from STOP (back-to-back frames, no idle gap required).
REQ-023 SHALL count tcnt modulo 16 with no overflow outside defined transitions.

Reset
REQ-024 SHALL, on rst_n=0, immediately force: state=IDLE, tcnt=0, bidx=0, os counter=0, shift register=0, synchronizer=1, data=8'h00, valid=0, frame_err=0, busy=0.
REQ-025 SHALL, on reset mid-frame, discard the partial byte; after release, a fresh start bit is required before any valid pulse.
REQ-026 SHALL leave reset synchronously-released behaviour defined: first os_tick no earlier than OS_COUNT clocks after rst_n rises.

Verification (CLK_FREQ=16_000_000, BAUD_RATE=1_000_000: OS_COUNT=1, 16 clocks/bit)
REQ-027 SHALL cover: frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data=8'hA5, valid one clock, frame_err=0, busy low afterward.
REQ-028 SHALL cover: rx low for 4 clocks then high -> START then IDLE, no valid, no frame_err, data unchanged.
REQ-029 SHALL cover: frame 0x3C with stop bit 0, rx held low 40 more clocks -> frame_err one clock, data=8'h3C, valid=0, busy high until rx high, then IDLE.
REQ-030 SHALL cover: back-to-back 0x00 then 0xFF, no idle gap -> two valid pulses, data 8'h00 then 8'hFF.
REQ-031 SHALL cover: rst_n low during bit 4 of 0x55, then full frame 0x81 -> no pulse for 0x55, data=8'h00 during reset, then data=8'h81 with valid.
REQ-032 SHALL cover: 1-clock rx glitches between sample points during frame 0x96 -> data=8'h96, valid, no frame_err.
